// File: rtl/id_issue_ctrl_pkg.sv
// Shared types and constants for the decode-to-execute issue controller.
// Optional macro ISSUE_WB_BYPASS_EN changes scoreboard hazard timing (see issue_scoreboard).
package id_issue_ctrl_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_X0 = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    typedef struct packed {
        logic             rs1_ren;
        logic [REG_W-1:0] rs1;
        logic             rs2_ren;
        logic [REG_W-1:0] rs2;
        logic             rd_wen;
        logic [REG_W-1:0] rd;
    } instr_t;

    function automatic logic is_x0(input logic [REG_W-1:0] r);
        return r == REG_X0;
    endfunction

endpackage

// File: rtl/id_issue_ctrl_scoreboard.sv
// In-order FIFO of destination registers for in-flight writers, with match lookup.
// With ISSUE_WB_BYPASS_EN defined, the entry retiring this cycle is invisible to match/full.
module issue_scoreboard
    import id_issue_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [REG_W-1:0] push_rd,
    input  logic             pop,
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    output logic             rs1_match,
    output logic             rs2_match,
    output logic             full,
    output logic             empty,
    output logic             underflow,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [REG_W-1:0] rd_q [DEPTH];
    logic [REG_W-1:0] rd_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             underflow_q, underflow_d;

    logic             pop_ok;
    logic             push_ok;
    logic             head_leaving;
    logic [DEPTH-1:0] live;

    assign empty   = (count_q == '0);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & ((count_q != FULL_CNT) | pop_ok);

`ifdef ISSUE_WB_BYPASS_EN
    assign head_leaving = pop_ok;
`else
    assign head_leaving = 1'b0;
`endif

    assign full      = (count_q == FULL_CNT) & ~head_leaving;
    assign count     = count_q;
    assign underflow = underflow_q;

    always_comb begin
        live      = valid_q;
        rs1_match = 1'b0;
        rs2_match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (head_leaving && (rd_ptr_q == PTR_W'(i))) begin
                live[i] = 1'b0;
            end
            if (live[i] && (rd_q[i] == rs1)) begin
                rs1_match = 1'b1;
            end
            if (live[i] && (rd_q[i] == rs2)) begin
                rs2_match = 1'b1;
            end
        end
    end

    // Push after pop so a full FIFO popping and pushing the same slot keeps the new entry.
    always_comb begin
        valid_d     = valid_q;
        rd_d        = rd_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        underflow_d = underflow_q | (pop & empty);
        if (pop_ok) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PTR_ONE;
        end
        if (push_ok) begin
            valid_d[wr_ptr_q] = 1'b1;
            rd_d[wr_ptr_q]    = push_rd;
            wr_ptr_d          = wr_ptr_q + PTR_ONE;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i] <= '0;
            end
        end else begin
            valid_q     <= valid_d;
            rd_q        <= rd_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: rtl/id_issue_ctrl.sv
// Issue controller: holds one decoded instruction, stalls on RAW/full hazards, issues to execute.
// Optional macro ISSUE_WB_BYPASS_EN lets a same-cycle retire clear a hazard one cycle earlier.
module id_issue_ctrl
    import id_issue_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_dec_req,
    output logic             o_dec_ack,
    input  logic             i_rs1_ren,
    input  logic [REG_W-1:0] i_rs1,
    input  logic             i_rs2_ren,
    input  logic [REG_W-1:0] i_rs2,
    input  logic             i_rd_wen,
    input  logic [REG_W-1:0] i_rd,
    output logic             o_issue_req,
    input  logic             i_issue_ack,
    input  logic             i_wb_retire,
    input  logic             i_flush,
    output logic             o_stall,
    output logic             o_busy,
    output logic [PTR_W:0]   o_inflight,
    output logic             o_underflow
);

    state_t state_q, state_d;
    instr_t instr_q, instr_d;

    logic rs1_match;
    logic rs2_match;
    logic sb_full;
    logic sb_empty;
    logic dec_fire;
    logic hazard;
    logic push;

    issue_scoreboard #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_rd   (instr_q.rd),
        .pop       (i_wb_retire),
        .rs1       (instr_q.rs1),
        .rs2       (instr_q.rs2),
        .rs1_match (rs1_match),
        .rs2_match (rs2_match),
        .full      (sb_full),
        .empty     (sb_empty),
        .underflow (o_underflow),
        .count     (o_inflight)
    );

    assign dec_fire = i_dec_req & o_dec_ack;

    assign hazard = (instr_q.rs1_ren & ~is_x0(instr_q.rs1) & rs1_match)
                  | (instr_q.rs2_ren & ~is_x0(instr_q.rs2) & rs2_match)
                  | (instr_q.rd_wen  & ~is_x0(instr_q.rd)  & sb_full);

    // A flush beats a simultaneous ack, so the dropped instruction never enters the scoreboard.
    assign push = (state_q == ST_ISSUE) & i_issue_ack & ~i_flush
                & instr_q.rd_wen & ~is_x0(instr_q.rd);

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (dec_fire && !i_flush) begin
                    instr_d.rs1_ren = i_rs1_ren;
                    instr_d.rs1     = i_rs1;
                    instr_d.rs2_ren = i_rs2_ren;
                    instr_d.rs2     = i_rs2;
                    instr_d.rd_wen  = i_rd_wen;
                    instr_d.rd      = i_rd;
                    state_d         = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (i_flush) begin
                    state_d = ST_IDLE;
                end else if (!hazard) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (i_flush || i_issue_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
        end
    end

    assign o_dec_ack   = (state_q == ST_IDLE);
    assign o_issue_req = (state_q == ST_ISSUE);
    assign o_stall     = (state_q == ST_CHECK) & hazard;
    assign o_busy      = (state_q != ST_IDLE) | ~sb_empty;

endmodule
